// File: rtl/wrr_round_tracker.sv
// wrr_round_tracker
//   Dequeue-side tracker for the WRR rank engine. Rank words popped from the
//   PIFO root ({tag_valid, overflow, round, addr}) are split into:
//     - the buffer address, pushed through a small FIFO to the packet reader
//     - the global virtual time {overflow, round}, fed back as last_pifo_*
//   Global time only moves forward; an overflow-epoch change with a smaller
//   round is treated as a wrap. Stale tags still release their address.
//
//   Optional build macro: WRR_ROUND_TRACKER_STATS_EN adds saturating
//   stale/advance event counters (stat_stale_cnt, stat_adv_cnt).
//
// Ports
//   clk, rstn            clock, async active-low reset
//   clear                sync tracker re-init (FIFO untouched)
//   deq_valid/ready/data rank word input handshake
//   addr_valid/ready/data released address output (FIFO head)
//   last_pifo_valid/overflow/round  global virtual time
//   round_adv            one-cycle pulse when global time changes
module wrr_round_tracker #(
  parameter int PIFO_OVERFLOW_WIDTH = 1,
  parameter int PIFO_ROUND_WIDTH    = 18,
  parameter int PIFO_ADDR_WIDTH     = 12,
  parameter int PIFO_WIDTH          = 32,
  parameter int OUT_DEPTH           = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           clear,
  input  logic                           deq_valid,
  input  logic [PIFO_WIDTH-1:0]          deq_data,
  output logic                           deq_ready,
  output logic                           addr_valid,
  output logic [PIFO_ADDR_WIDTH-1:0]     addr_data,
  input  logic                           addr_ready,
  output logic                           last_pifo_valid,
  output logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow,
  output logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round,
  output logic                           round_adv
`ifdef WRR_ROUND_TRACKER_STATS_EN
  ,
  output logic [31:0]                    stat_stale_cnt,
  output logic [31:0]                    stat_adv_cnt
`endif
);

  localparam int OW = PIFO_OVERFLOW_WIDTH;
  localparam int RW = PIFO_ROUND_WIDTH;
  localparam int AW = PIFO_ADDR_WIDTH;
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {INIT, TRACK} state_t;

  // ---------------- S1: accepted word register ----------------
  logic          accept;
  logic          s1_valid;
  logic [OW-1:0] s1_ovf;
  logic [RW-1:0] s1_round;
  logic [AW-1:0] s1_addr;

  assign accept = deq_valid & deq_ready;

  // Words with tag_valid=0 are consumed here and never enter S1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_ovf   <= '0;
      s1_round <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= accept & deq_data[PIFO_WIDTH-1];
      if (accept) begin
        s1_ovf   <= deq_data[AW+RW +: OW];
        s1_round <= deq_data[AW +: RW];
        s1_addr  <= deq_data[AW-1:0];
      end
    end
  end

  // ---------------- address FIFO ----------------
  logic [OUT_DEPTH-1:0][AW-1:0] mem;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count;
  logic [CW:0]                  occ;
  logic                         push, pop;

  assign push       = s1_valid;
  assign addr_valid = (count != '0);
  assign pop        = addr_valid & addr_ready;
  assign addr_data  = mem[rd_ptr];

  // Occupancy includes S1 so the in-flight word always has a FIFO slot.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, s1_valid};
  assign deq_ready = occ < (CW+1)'(OUT_DEPTH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s1_addr;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- tracker FSM ----------------
  state_t        state, nxt_state;
  logic [OW-1:0] cur_ovf, nxt_ovf;
  logic [RW-1:0] cur_round, nxt_round;
  logic          adv, stale;

  always_comb begin
    nxt_state = state;
    nxt_ovf   = cur_ovf;
    nxt_round = cur_round;
    adv       = 1'b0;
    stale     = 1'b0;
    if (s1_valid) begin
      unique case (state)
        INIT: begin
          nxt_state = TRACK;
          nxt_ovf   = s1_ovf;
          nxt_round = s1_round;
          adv       = 1'b1;
        end
        TRACK: begin
          if (s1_ovf == cur_ovf) begin
            if (s1_round > cur_round) begin
              nxt_round = s1_round;
              adv       = 1'b1;
            end else if (s1_round < cur_round) begin
              stale = 1'b1;
            end
          end else if (s1_round < cur_round) begin
            // New epoch with a smaller round: the round counter wrapped.
            nxt_ovf   = s1_ovf;
            nxt_round = s1_round;
            adv       = 1'b1;
          end else begin
            // Other epoch with round >= ours: leftover from the prior epoch.
            stale = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // clear overrides any S1 evaluation; the address still goes to the FIFO.
    if (clear) begin
      nxt_state = INIT;
      nxt_ovf   = '0;
      nxt_round = '0;
      adv       = 1'b0;
      stale     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= INIT;
      cur_ovf   <= '0;
      cur_round <= '0;
      round_adv <= 1'b0;
    end else begin
      state     <= nxt_state;
      cur_ovf   <= nxt_ovf;
      cur_round <= nxt_round;
      round_adv <= adv;
    end
  end

  assign last_pifo_valid    = (state == TRACK);
  assign last_pifo_overflow = cur_ovf;
  assign last_pifo_round    = cur_round;

`ifdef WRR_ROUND_TRACKER_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_stale_cnt <= '0;
      stat_adv_cnt   <= '0;
    end else if (clear) begin
      stat_stale_cnt <= '0;
      stat_adv_cnt   <= '0;
    end else begin
      if (stale && stat_stale_cnt != '1) stat_stale_cnt <= stat_stale_cnt + 32'd1;
      if (adv && stat_adv_cnt != '1)     stat_adv_cnt   <= stat_adv_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/wrr_round_tracker.md
Name: wrr_round_tracker

Overview:
- Dequeue-side counterpart of the WRR rank engine.
- Consumes rank words popped from the PIFO root, formatted {tag_valid, overflow, round, addr}, and splits them into two outputs:
  - the buffer address, forwarded to the packet buffer reader through a small output FIFO;
  - the global virtual time {overflow, round}, fed back to the engine as last_pifo_*.
- Global time advances monotonically and is aware of overflow-epoch wrap. Stale tags still release their address but never move time backwards.

Parameters:
- PIFO_OVERFLOW_WIDTH, 1, epoch bit width (only 1 supported).
- PIFO_ROUND_WIDTH, 18, round field width.
- PIFO_ADDR_WIDTH, 12, buffer address width.
- PIFO_WIDTH, 32, rank word width; must equal 1+PIFO_OVERFLOW_WIDTH+PIFO_ROUND_WIDTH+PIFO_ADDR_WIDTH.
- OUT_DEPTH, 4, address FIFO depth (power of 2, ≥2).

Ports:
- clk, in, 1, sole clock.
- rstn, in, 1, asynchronous active-low reset.
- clear, in, 1, synchronous tracker re-init.
- deq_valid, in, 1, rank word present.
- deq_data, in, PIFO_WIDTH, rank word [MSB]=tag_valid, then overflow, round, addr[LSBs].
- deq_ready, out, 1, word accepted when deq_valid&deq_ready.
- addr_valid, out, 1, address FIFO head valid.
- addr_data, out, PIFO_ADDR_WIDTH, buffer address to release.
- addr_ready, in, 1, consumer pop.
- last_pifo_valid, out, 1, global time initialised.
- last_pifo_overflow, out, PIFO_OVERFLOW_WIDTH, global epoch.
- last_pifo_round, out, PIFO_ROUND_WIDTH, global round.
- round_adv, out, 1, one-cycle pulse when global time changes.

Behaviour:
- Reset (async, rstn=0): all outputs 0 except deq_ready=1. FIFO empty, S1 empty, state INIT. Release is synchronous to clk.
- Stage S1: registers accepted words at the end of accept cycle T.
- Cycle T+1:
  - S1 is evaluated.
  - Tracker registers and the FIFO write update at the end of T+1.
  - last_pifo_* and round_adv are visible at T+2; addr_valid rises at T+2 if the FIFO was empty. Latency is 2 cycles.
- deq_ready = (fifo_count + s1_valid) < OUT_DEPTH. With addr_ready held high, throughput is 1 word/clk.
- tag_valid=0 words: accepted and dropped. No FIFO write, no tracking effect.
- States: INIT, TRACK.
  - INIT: first valid tag is adopted unconditionally. Set overflow/round, last_pifo_valid=1, round_adv=1, go to TRACK.
  - TRACK, current (co,cr), tag (o,r):
    - o==co, r>cr: advance, round_adv=1.
    - o==co, r==cr: no change, no pulse.
    - o==co, r<cr: stale, no change.
    - o!=co, r<cr: epoch wrap, adopt (o,r), round_adv=1.
    - o!=co, r>=cr: stale (prior-epoch leftover), no change.
- The address of every tag_valid=1 word, stale or not, is written to the FIFO in order.
- FIFO:
  - Simultaneous push and pop when full or empty is legal; count is unchanged.
  - Never overflows, because deq_ready accounts for S1.
  - addr_data holds stable while addr_valid & !addr_ready.
- clear in cycle C:
  - At the end of C: state←INIT, last_pifo_valid/overflow/round←0, round_adv←0.
  - A word in S1 during C still writes its address to the FIFO but is ignored for tracking (clear wins).
  - The FIFO contents and any word accepted in C are unaffected; the word accepted in C is evaluated against INIT next cycle.
- Round wrap at ROUND_MAX: handled only via the epoch rule. No arithmetic is performed on round, so no width growth.

Optional Feature:
- Macro WRR_ROUND_TRACKER_STATS_EN.
- When defined, adds outputs stat_stale_cnt[31:0] and stat_adv_cnt[31:0].
  - Each counts events at the S1 evaluation edge and saturates at 2^32-1.
  - Both reset to 0 on rstn or clear.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then word {1,0,5,0x00A} at cycle 0 → at cycle 2: last_pifo_valid=1, overflow=0, round=5, round_adv=1 for one cycle, addr_valid=1, addr_data=0x00A.
- TRACK at (0,5), feed rounds 7, 7, 3 back-to-back with addr_ready=1 → round goes 7 and stays 7; round_adv pulses once; addresses come out in order; stat_stale_cnt=1 with the macro defined.
- At (0,262143), feed (1,0) then (0,262140) → global (1,0) with round_adv=1; the second word is stale, time stays (1,0), and its address is still output.
- addr_ready=0, stream 6 valid words → deq_ready drops after 4 accepted (FIFO 4, S1 0); raise addr_ready → all 6 addresses arrive in order with no loss or duplication.
- Word with tag_valid=0 → no addr_valid, no time change, deq_ready remains 1.
- At (0,9), assert clear in the same cycle S1 holds (0,12) → its address is output, time goes to 0 with last_pifo_valid=0; the next word (0,2) is adopted, giving round=2 and last_pifo_valid=1.
